// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants and read-channel FSM encoding
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi_rd_line_buf.sv
// rtl/axi_rd_line_buf.sv - beat-addressed line buffer with flat line output
module axi_rd_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 8,
    localparam int CNT_W     = $clog2(BEATS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_i,
    input  logic [CNT_W-1:0]            idx_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    output logic [DATA_WIDTH*BEATS-1:0] line_o
);

    // Slots persist between bursts so the previous line stays visible until overwritten.
    for (genvar g = 0; g < BEATS; g++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (we_i && (idx_i == CNT_W'(g))) begin
                slot_q <= wdata_i;
            end
        end

        assign line_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end

endmodule

// File: rtl/axi_master_read_channel.sv
// rtl/axi_master_read_channel.sv - single-outstanding AXI read burst master for line refills (option: AXI_RD_LAST_CHECK_EN)
module axi_master_read_channel
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_WIDTH*BEATS-1:0] resp_data,
    output logic                        resp_err,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [ADDR_WIDTH-1:0]       ARADDR,
    output logic [7:0]                  ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [DATA_WIDTH-1:0]       RDATA,
    input  logic                        RLAST,
    input  logic [1:0]                  RRESP
);

    localparam int CNT_W = $clog2(BEATS);
    localparam int LINE_OFF = $clog2(BEATS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << LINE_OFF;

    rd_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   err_q, err_d;
    logic                   beat;
    logic                   last_beat;

    assign beat      = RVALID && (state_q == ST_DATA);
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d  = ST_ADDR;
                    araddr_d = req_addr & ALIGN_MASK;
                    err_d    = 1'b0;
                end
            end
            ST_ADDR: begin
                if (ARREADY) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (RRESP == RRESP_SLVERR || RRESP == RRESP_DECERR) begin
                        err_d = 1'b1;
                    end
`ifdef AXI_RD_LAST_CHECK_EN
                    if (RLAST != last_beat) begin
                        err_d = 1'b1;
                    end
`endif
                    // Beat count alone decides the end of the burst.
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            araddr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

`ifndef AXI_RD_LAST_CHECK_EN
    logic unused_rlast;
    assign unused_rlast = RLAST;
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign ARVALID    = (state_q == ST_ADDR);
    assign RREADY     = (state_q == ST_DATA);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = err_q;
    assign ARADDR     = araddr_q;
    assign ARLEN      = 8'(BEATS - 1);
    assign ARSIZE     = 3'($clog2(DATA_WIDTH / 8));
    assign ARBURST    = AXI_BURST_INCR;

    axi_rd_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (beat),
        .idx_i   (beat_cnt_q),
        .wdata_i (RDATA),
        .line_o  (resp_data)
    );

endmodule

// File: tb/tb_axi_master_read_channel.sv
// tb/tb_axi_master_read_channel.sv - randomized self-checking bench for axi_master_read_channel
module tb_axi_master_read_channel;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 8;
    localparam int LW = DW * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [LW-1:0] resp_data;
    logic          resp_err;
    logic          ARVALID;
    logic          ARREADY;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          RVALID;
    logic          RREADY;
    logic [DW-1:0] RDATA;
    logic          RLAST;
    logic [1:0]    RRESP;

    int checks = 0;
    int errors = 0;

    // Reference model of one refill.
    logic [DW-1:0] beat_data [NB];
    logic [1:0]    beat_resp [NB];
    int            last_pos;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] prev_line;
    logic          exp_err;
    int            beat_idx;

    always #5 clk = ~clk;

    axi_master_read_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP)
    );

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setup_line(input bit fixed, input logic [NB-1:0] emask, input int lpos);
        exp_line = '0;
        for (int k = 0; k < NB; k++) begin
            beat_data[k] = fixed ? DW'(32'hA0 + k) : DW'($urandom);
            beat_resp[k] = emask[k] ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
            exp_line[k*DW +: DW] = beat_data[k];
        end
        last_pos = lpos;
        exp_err  = |emask;
`ifdef AXI_RD_LAST_CHECK_EN
        if (lpos != NB - 1) exp_err = 1'b1;
`endif
    endtask

    task automatic start_req(input logic [AW-1:0] addr, input int ar_wait);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        check_eq("req_ready_idle", LW'(req_ready), LW'(1));
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("arvalid", LW'(ARVALID), LW'(1));
        check_eq("araddr", LW'(ARADDR), LW'((addr / 32) * 32));
        check_eq("arlen", LW'(ARLEN), LW'(NB - 1));
        check_eq("arsize", LW'(ARSIZE), LW'(2));
        check_eq("arburst", LW'(ARBURST), LW'(1));
        check_eq("line_kept", resp_data, prev_line);
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            check_eq("arvalid_hold", LW'(ARVALID), LW'(1));
            check_eq("rready_in_addr", LW'(RREADY), LW'(0));
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY  = 1'b0;
        beat_idx = 0;
        check_eq("rready_data", LW'(RREADY), LW'(1));
        check_eq("arvalid_drop", LW'(ARVALID), LW'(0));
    endtask

    // mode 0: back-to-back beats, 1: valid every other cycle, 2: random gaps
    task automatic send_beats(input int n, input int mode);
        int cyc = 0;
        int sent = 0;
        bit v;
        while (sent < n && cyc < 200) begin
            case (mode)
                0: v = 1'b1;
                1: v = cyc[0] == 1'b0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            RVALID = v;
            RDATA  = beat_data[beat_idx];
            RRESP  = beat_resp[beat_idx];
            RLAST  = (beat_idx == last_pos);
            @(negedge clk);
            if (v) begin
                beat_idx++;
                sent++;
            end
            cyc++;
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        if (sent < n) check_eq("beat_timeout", LW'(sent), LW'(n));
    endtask

    task automatic finish_resp(input int rr_wait, input bit hold_req);
        check_eq("resp_valid", LW'(resp_valid), LW'(1));
        check_eq("rready_resp", LW'(RREADY), LW'(0));
        for (int i = 0; i < rr_wait; i++) begin
            req_valid = hold_req;
            @(negedge clk);
            check_eq("resp_valid_hold", LW'(resp_valid), LW'(1));
            check_eq("resp_stable", resp_data, exp_line);
            check_eq("req_ready_resp", LW'(req_ready), LW'(0));
        end
        req_valid = 1'b0;
        check_eq("resp_data", resp_data, exp_line);
        check_eq("resp_err", LW'(resp_err), LW'(exp_err));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("resp_valid_drop", LW'(resp_valid), LW'(0));
        check_eq("req_ready_back", LW'(req_ready), LW'(1));
        prev_line = exp_line;
    endtask

    task automatic refill(input logic [AW-1:0] addr, input int ar_wait, input int mode,
                          input int rr_wait, input bit hold_req);
        start_req(addr, ar_wait);
        send_beats(NB, mode);
        finish_resp(rr_wait, hold_req);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_arvalid", LW'(ARVALID), LW'(0));
        check_eq("rst_rready", LW'(RREADY), LW'(0));
        check_eq("rst_resp_valid", LW'(resp_valid), LW'(0));
        check_eq("rst_resp_err", LW'(resp_err), LW'(0));
        check_eq("rst_araddr", LW'(ARADDR), LW'(0));
        check_eq("rst_resp_data", resp_data, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
        prev_line = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("req_ready_after_rst", LW'(req_ready), LW'(1));

        // Nominal refill
        setup_line(1'b1, 8'h00, NB - 1);
        for (int k = 0; k < NB; k++) beat_resp[k] = 2'b00;
        refill(32'h1234, 0, 0, 0, 1'b0);

        // Backpressure on AR, R and response
        setup_line(1'b0, 8'h00, NB - 1);
        refill(32'h0000_8F7C, 3, 1, 4, 1'b1);

        // Error on beat 3 only, then a clean refill
        setup_line(1'b0, 8'h08, NB - 1);
        refill(32'h4000_0040, 1, 0, 1, 1'b0);
        setup_line(1'b0, 8'h00, NB - 1);
        refill(32'h4000_0060, 0, 2, 0, 1'b0);

        // Early RLAST on beat 6
        setup_line(1'b0, 8'h00, 6);
        refill(32'h0000_0100, 0, 0, 0, 1'b0);

        // Reset after beat 4 of a burst
        setup_line(1'b0, 8'h00, NB - 1);
        start_req(32'h0000_0ABC, 0);
        send_beats(5, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        prev_line = '0;
        @(negedge clk);
        check_eq("req_ready_post_abort", LW'(req_ready), LW'(1));
        setup_line(1'b0, 8'h00, NB - 1);
        refill(32'h0000_0ABC, 0, 0, 0, 1'b0);

        // Randomized refills
        for (int t = 0; t < 30; t++) begin
            logic [NB-1:0] emask;
            emask = '0;
            for (int k = 0; k < NB; k++) emask[k] = ($urandom_range(0, 7) == 0);
            setup_line(1'b0, emask, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : NB - 1);
            refill($urandom, $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_master_read_channel.md
AXI_MASTER_READ_CHANNEL -- requirements
Module: axi_master_read_channel

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, R beat width in bits.
REQ-003 SHALL have parameter BEATS, default 8, beats per line refill; power of two, 2..256.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset. One clock only; rst_n is asynchronous, active-low.
REQ-005 SHALL have ports: req_valid in 1, req_ready out 1, req_addr in ADDR_WIDTH; line-refill request from the cache.
REQ-006 SHALL have ports: resp_valid out 1, resp_ready in 1, resp_data out DATA_WIDTH*BEATS, resp_err out 1; the returned line, with beat 0 in the LSBs.
REQ-007 SHALL have ports: ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH, ARLEN out 8, ARSIZE out 3, ARBURST out 2.
REQ-008 SHALL have ports: RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RLAST in 1, RRESP in 2.

Function
REQ-009 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE, with one outstanding burst at a time.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, and the FSM enters ADDR on the next cycle.
REQ-011 SHALL latch ARADDR at acceptance as req_addr with the low log2(BEATS*DATA_WIDTH/8) bits cleared, i.e. line-aligned.
REQ-012 SHALL drive ARLEN=BEATS-1, ARSIZE=log2(DATA_WIDTH/8) and ARBURST=2'b01 (INCR); these SHALL be stable whenever ARVALID=1.
REQ-013 SHALL hold ARVALID=1 throughout ADDR, independent of ARREADY, and go to DATA on the cycle after ARVALID&&ARREADY.
REQ-014 SHALL drive RREADY=1 throughout DATA and 0 in every other state.
REQ-015 SHALL write each beat (RVALID&&RREADY) into slot beat_cnt of the line buffer, then increment beat_cnt; beat_cnt is cleared on entry to DATA.
REQ-016 SHALL leave DATA for RESP on the handshake where beat_cnt==BEATS-1; RLAST is ignored unless REQ-024 applies.
REQ-017 SHALL set the sticky flag err when any accepted beat has RRESP[1]=1; err is cleared at request acceptance.
REQ-018 SHALL hold resp_valid=1 in RESP, with resp_data and resp_err=err stable, until resp_valid&&resp_ready, then return to IDLE.
REQ-019 SHALL cover a req_valid held high during RESP: req_ready stays 0 and the request is accepted no earlier than the first IDLE cycle.
REQ-020 SHALL keep resp_data at the previous line's contents until the next burst overwrites it slot by slot.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-burst, enter IDLE immediately and clear ARVALID, RREADY, resp_valid, resp_err, err, beat_cnt, ARADDR and resp_data to 0.
REQ-022 SHALL drive req_ready=1 after reset release; beats of an interrupted burst are not the block's concern.

Configuration
REQ-023 SHALL use the macro AXI_RD_LAST_CHECK_EN as its single compile-time option.
REQ-024 SHALL, with AXI_RD_LAST_CHECK_EN defined, set err on any beat whose RLAST differs from (beat_cnt==BEATS-1); the beat count still governs the exit from DATA.
REQ-025 SHALL, without AXI_RD_LAST_CHECK_EN, ignore RLAST entirely and have no check logic.

Structure
REQ-026 SHALL use the shared package axi_pkg for the AXI_BURST_INCR constant, the RRESP codes (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state encoding.
REQ-027 SHALL place the line buffer in the sub-module axi_rd_line_buf, which has a write-enable, a beat index and write data, and a flat line output.

Verification
REQ-028 SHALL verify nominal refill: req_addr=0x1234 with the slave returning 0xA0..0xA7 -> ARADDR=0x1220, ARLEN=7, ARSIZE=2, ARBURST=1; resp_data beat k=0xA0+k; resp_err=0.
REQ-029 SHALL verify backpressure: ARREADY low for 3 cycles, RVALID toggling every other cycle, resp_ready low for 4 cycles -> ARVALID is held, all 8 beats are captured in order, and resp_valid is held with stable data.
REQ-030 SHALL verify error: RRESP=2'b10 on beat 3 only -> resp_err=1; the next clean request returns resp_err=0.
REQ-031 SHALL verify reset mid-burst: rst_n asserted after beat 4 -> next cycle IDLE, all outputs 0, and a following request completes normally.
REQ-032 SHALL verify, with AXI_RD_LAST_CHECK_EN, RLAST=1 on beat 6 -> resp_err=1 and 8 beats are still consumed; without the macro, resp_err=0.
